// File: rtl/ctr_pkg.sv
// Shared counter definitions: direction encoding and the modulo step
// function. Reused by future cascaded counters, so it is not tied to any one
// counter width. Values are carried in CTR_MAX_W bits and callers
// zero-extend or truncate at the boundary.
package ctr_pkg;

    localparam int unsigned CTR_MAX_W = 32;

    localparam logic DIR_UP = 1'b1;
    localparam logic DIR_DN = 1'b0;

    // Returns {wrap, next}. The limit test is done before the increment, so a
    // non-power-of-2 modulus never yields an out-of-range intermediate value.
    function automatic logic [CTR_MAX_W:0] next_mod(
        input logic [CTR_MAX_W-1:0] cur,
        input logic                 up,
        input logic [CTR_MAX_W-1:0] modulus
    );
        logic [CTR_MAX_W-1:0] top_s;
        logic [CTR_MAX_W:0]   res_s;
        top_s = modulus - 32'd1;
        if (up == DIR_UP) begin
            if (cur == top_s) begin
                res_s = {1'b1, 32'd0};
            end else begin
                res_s = {1'b0, cur + 32'd1};
            end
        end else begin
            if (cur == 32'd0) begin
                res_s = {1'b1, top_s};
            end else begin
                res_s = {1'b0, cur - 32'd1};
            end
        end
        return res_s;
    endfunction

endpackage

// File: rtl/updown_mod_counter_mod_step.sv
// Combinational next-state logic for the modulo counter: load has priority
// over stepping, and an enabled step wraps at the modulus boundary.
module mod_step
    import ctr_pkg::*;
#(
    parameter int WIDTH   = 4,
    parameter int MODULUS = 16
) (
    input  logic [WIDTH-1:0] cur,
    input  logic             up_dn,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] nxt,
    output logic             wrap_up,
    output logic             wrap_dn,
    output logic             bad_load
);

    localparam logic [CTR_MAX_W-1:0] MOD_W = CTR_MAX_W'(MODULUS);
    localparam logic [WIDTH-1:0]     TOP_W = WIDTH'(MODULUS - 1);

    logic [CTR_MAX_W-1:0] cur_ext_s;
    logic [CTR_MAX_W-1:0] ld_ext_s;
    logic [CTR_MAX_W:0]   step_s;
    logic                 unused_step_s;

    // Widen the current count and the load value to the package width.
    always_comb begin
        cur_ext_s             = '0;
        ld_ext_s              = '0;
        cur_ext_s[WIDTH-1:0]  = cur;
        ld_ext_s[WIDTH-1:0]   = load_val;
    end

    assign step_s        = next_mod(cur_ext_s, up_dn, MOD_W);
    assign unused_step_s = ^step_s[CTR_MAX_W-1:0];

    // Select next count and event flags: load beats step, step beats hold.
    always_comb begin
        nxt      = cur;
        wrap_up  = 1'b0;
        wrap_dn  = 1'b0;
        bad_load = 1'b0;
        if (load) begin
            if (ld_ext_s < MOD_W) begin
                nxt = load_val;
            end else begin
                nxt      = TOP_W;
                bad_load = 1'b1;
            end
        end else if (en) begin
            nxt     = step_s[WIDTH-1:0];
            wrap_up = step_s[CTR_MAX_W] & (up_dn == DIR_UP);
            wrap_dn = step_s[CTR_MAX_W] & (up_dn == DIR_DN);
        end else begin
            nxt = cur;
        end
    end

endmodule

// File: rtl/updown_mod_counter.sv
// Loadable modulo-N up/down counter. Holds only the state registers and the
// terminal-count decode; next-state logic lives in mod_step.
module updown_mod_counter
    import ctr_pkg::*;
#(
    parameter int WIDTH   = 4,
    parameter int MODULUS = 16,
    parameter int RST_VAL = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             up_dn,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             carry,
    output logic             borrow,
    output logic             load_err
);

    // Reject parameter sets that would let the count leave 0..MODULUS-1.
    if ((WIDTH < 1) || (WIDTH > CTR_MAX_W) || (MODULUS < 2) ||
        (longint'(MODULUS) > (64'sd1 <<< WIDTH)) ||
        (RST_VAL < 0) || (RST_VAL >= MODULUS)) begin : g_bad_params
        $error("updown_mod_counter: illegal WIDTH/MODULUS/RST_VAL combination");
    end

    localparam logic [WIDTH-1:0] RST_W = WIDTH'(RST_VAL);
    localparam logic [WIDTH-1:0] TOP_W = WIDTH'(MODULUS - 1);

    logic [WIDTH-1:0] count_r;
    logic             carry_r;
    logic             borrow_r;
    logic             load_err_r;
    logic [WIDTH-1:0] nxt_s;
    logic             wrap_up_s;
    logic             wrap_dn_s;
    logic             bad_load_s;
    logic             tc_s;

    mod_step #(
        .WIDTH   (WIDTH),
        .MODULUS (MODULUS)
    ) u_step (
        .cur      (count_r),
        .up_dn    (up_dn),
        .en       (en),
        .load     (load),
        .load_val (load_val),
        .nxt      (nxt_s),
        .wrap_up  (wrap_up_s),
        .wrap_dn  (wrap_dn_s),
        .bad_load (bad_load_s)
    );

    // Count and one-cycle event pulses; reset discards any load/step.
    always_ff @(posedge clk) begin
        if (!reset) begin
            count_r    <= RST_W;
            carry_r    <= 1'b0;
            borrow_r   <= 1'b0;
            load_err_r <= 1'b0;
        end else begin
            count_r    <= nxt_s;
            carry_r    <= wrap_up_s;
            borrow_r   <= wrap_dn_s;
            load_err_r <= bad_load_s;
        end
    end

    // Terminal count follows the live direction input with no latency.
    always_comb begin
        tc_s = 1'b0;
        if (up_dn == DIR_UP) begin
            tc_s = (count_r == TOP_W);
        end else begin
            tc_s = (count_r == {WIDTH{1'b0}});
        end
    end

    assign count    = count_r;
    assign carry    = carry_r;
    assign borrow   = borrow_r;
    assign load_err = load_err_r;
    assign tc       = tc_s;

endmodule

// File: tb/tb_updown_mod_counter.sv
// Self-checking bench: directed scenarios followed by random traffic, all
// compared against a plain-arithmetic modulo model.
module tb_updown_mod_counter;

    localparam int W   = 4;
    localparam int MOD = 10;

    logic         clk = 1'b0;
    logic         reset;
    logic         en;
    logic         up_dn;
    logic         load;
    logic [W-1:0] load_val;
    logic [W-1:0] count;
    logic         tc;
    logic         carry;
    logic         borrow;
    logic         load_err;

    int n_chk  = 0;
    int n_pass = 0;

    // reference model state
    int m_count = 0;
    int m_carry = 0;
    int m_borrow = 0;
    int m_lerr = 0;
    bit m_valid = 1'b0;

    updown_mod_counter #(.WIDTH(W), .MODULUS(MOD), .RST_VAL(0)) dut (
        .clk      (clk),
        .reset    (reset),
        .en       (en),
        .up_dn    (up_dn),
        .load     (load),
        .load_val (load_val),
        .count    (count),
        .tc       (tc),
        .carry    (carry),
        .borrow   (borrow),
        .load_err (load_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        assert (got === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    endtask

    function automatic int model_tc(input int c, input logic u);
        return ((u && c == MOD - 1) || (!u && c == 0)) ? 1 : 0;
    endfunction

    // One clock cycle: drive, check tc before the edge, advance model, check after.
    task automatic step(input logic r, input logic e, input logic u,
                        input logic l, input int lv);
        reset = r; en = e; up_dn = u; load = l; load_val = W'(lv);
        #1;
        if (m_valid) check("tc_pre", {31'd0, tc}, model_tc(m_count, u));
        @(posedge clk);
        m_carry = 0; m_borrow = 0; m_lerr = 0;
        if (!r) begin
            m_count = 0;
            m_valid = 1'b1;
        end else if (l) begin
            if (lv < MOD) m_count = lv;
            else begin m_count = MOD - 1; m_lerr = 1; end
        end else if (e) begin
            if (u) begin
                m_carry = (m_count + 1 == MOD) ? 1 : 0;
                m_count = (m_count + 1) % MOD;
            end else begin
                m_borrow = (m_count == 0) ? 1 : 0;
                m_count = (m_count + MOD - 1) % MOD;
            end
        end
        #1;
        check("count",    {28'd0, count},    m_count);
        check("carry",    {31'd0, carry},    m_carry);
        check("borrow",   {31'd0, borrow},   m_borrow);
        check("load_err", {31'd0, load_err}, m_lerr);
        check("tc_post",  {31'd0, tc},       model_tc(m_count, u));
    endtask

    initial begin
        reset = 1'b0; en = 1'b1; up_dn = 1'b1; load = 1'b1; load_val = 4'd5;
        @(negedge clk);

        // 1: reset wins over load and en for two edges
        step(1'b0, 1'b1, 1'b1, 1'b1, 5);
        step(1'b0, 1'b1, 1'b1, 1'b1, 7);
        check("rst_count", {28'd0, count}, 32'd0);

        // 2: up count 0..9 then wrap to 0 with carry
        for (int i = 0; i < 10; i++) step(1'b1, 1'b1, 1'b1, 1'b0, 0);
        check("upwrap_carry", {31'd0, carry}, 32'd1);

        // 3: load 0, then step down to wrap at 9 with borrow
        step(1'b1, 1'b0, 1'b0, 1'b1, 0);
        step(1'b1, 1'b1, 1'b0, 1'b0, 0);
        check("dnwrap_count", {28'd0, count}, 32'd9);
        step(1'b1, 1'b1, 1'b0, 1'b0, 0);

        // 4: load priority over en, then out-of-range load
        step(1'b1, 1'b0, 1'b1, 1'b1, 5);
        step(1'b1, 1'b1, 1'b1, 1'b1, 3);
        step(1'b1, 1'b1, 1'b1, 1'b1, 12);
        check("ldbad_count", {28'd0, count}, 32'd9);
        step(1'b1, 1'b0, 1'b1, 1'b0, 0);

        // 5: at 9, flip direction to down with en
        step(1'b1, 1'b0, 1'b0, 1'b1, 9);
        step(1'b1, 1'b1, 1'b0, 1'b0, 0);

        // 6: mid-run reset at 7 while counting up, then resume
        step(1'b1, 1'b0, 1'b1, 1'b1, 7);
        step(1'b0, 1'b1, 1'b1, 1'b0, 0);
        step(1'b1, 1'b1, 1'b1, 1'b0, 0);
        step(1'b1, 1'b1, 1'b1, 1'b0, 0);

        // random traffic
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 39) != 0),
                 ($urandom_range(0, 3) != 0),
                 $urandom_range(0, 1) == 1,
                 ($urandom_range(0, 7) == 0),
                 int'($urandom_range(0, 15)));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
